i2c_slave_responder: RTL and testbench



---
 rtl/i2c_slave_responder.sv | 217 +++++++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: I2C target that matches a 7-bit device address, takes a
// 1- or 2-byte memory pointer, then writes to or streams from a synchronous
// memory port with pointer auto-increment. SCL/SDA are oversampled on clk.
// Optional: define I2C_SLAVE_GLITCH_FILTER_EN to add a 3-sample filter on SCL/SDA.
module i2c_slave_responder #(
    parameter logic [6:0] P_SLAVE_ADDR = 7'h50,
    parameter int         P_ADDR_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_i2c_scl,
    inout  wire                     io_i2c_sda,
    output logic [P_ADDR_WIDTH-1:0] o_mem_addr,
    output logic [7:0]              o_mem_wdata,
    output logic                    o_mem_wen,
    output logic                    o_mem_ren,
    input  logic [7:0]              i_mem_rdata,
    output logic                    o_busy
);

    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, DEV_ACK, PTR_MSB, MSB_ACK, PTR_LSB, LSB_ACK,
        WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    localparam logic [P_ADDR_WIDTH-1:0] PTR_ONE = 1;

    state_t                  state_q, state_d;
    logic [1:0]              scl_sync, sda_sync;
    logic                    scl_f, sda_f, scl_prev, sda_prev;
    logic                    scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]              shreg;
    logic [2:0]              bit_cnt;
    logic                    done, ack_bit, wen_pend, rd_wait, sda_oe;
    logic [P_ADDR_WIDTH-1:0] ptr;
    logic                    addr_match;

    // Two-flop synchronizers; bus idles high so reset to 1 to avoid false edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], i_i2c_scl};
            sda_sync <= {sda_sync[0], io_i2c_sda};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] scl_hist, sda_hist;

    // Filtered level follows the input only after 3 consecutive equal samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            if (&{scl_hist, scl_sync[1]})       scl_f <= 1'b1;
            else if (~|{scl_hist, scl_sync[1]}) scl_f <= 1'b0;
            if (&{sda_hist, sda_sync[1]})       sda_f <= 1'b1;
            else if (~|{sda_hist, sda_sync[1]}) sda_f <= 1'b0;
        end
    end
`else
    assign scl_f = scl_sync[1];
    assign sda_f = sda_sync[1];
`endif

    // Previous-value registers for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_f;
            sda_prev <= sda_f;
        end
    end

    // START/STOP need SCL steady high, so a coincident SCL edge counts as a data edge
    assign scl_rise   = scl_f & ~scl_prev;
    assign scl_fall   = ~scl_f & scl_prev;
    assign start_det  = scl_f & scl_prev & sda_prev & ~sda_f;
    assign stop_det   = scl_f & scl_prev & ~sda_prev & sda_f;
    assign addr_match = (shreg[7:1] == P_SLAVE_ADDR);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: byte and ACK phases advance on the SCL falling edge
    always_comb begin
        state_d = state_q;
        if (stop_det)       state_d = IDLE;
        else if (start_det) state_d = DEV_ADDR;
        else if (scl_fall && done) begin
            case (state_q)
                DEV_ADDR: state_d = addr_match ? DEV_ACK : IGNORE;
                DEV_ACK:  state_d = shreg[0] ? RD_DATA :
                                    (P_ADDR_WIDTH == 16) ? PTR_MSB : PTR_LSB;
                PTR_MSB:  state_d = MSB_ACK;
                MSB_ACK:  state_d = PTR_LSB;
                PTR_LSB:  state_d = LSB_ACK;
                LSB_ACK:  state_d = WR_DATA;
                WR_DATA:  state_d = WR_ACK;
                WR_ACK:   state_d = WR_DATA;
                RD_DATA:  state_d = RD_ACK;
                RD_ACK:   state_d = ack_bit ? IGNORE : RD_DATA;
                default:  state_d = state_q;
            endcase
        end
    end

    // Outputs decoded from state; SDA is open-drain
    always_comb begin
        o_busy = (state_q != IDLE);
    end

    assign io_i2c_sda = sda_oe ? 1'b0 : 1'bz;

    // Datapath: shift register, bit counter, pointer, SDA drive and memory strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            done        <= 1'b0;
            ack_bit     <= 1'b1;
            ptr         <= '0;
            wen_pend    <= 1'b0;
            rd_wait     <= 1'b0;
            sda_oe      <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_wen   <= 1'b0;
            o_mem_ren   <= 1'b0;
        end else begin
            o_mem_wen <= 1'b0;
            o_mem_ren <= 1'b0;
            wen_pend  <= 1'b0;
            rd_wait   <= o_mem_ren;
            // Write strobe lands one clk after the 8th rising edge
            if (wen_pend) begin
                o_mem_wen   <= 1'b1;
                o_mem_wdata <= shreg;
                o_mem_addr  <= ptr;
            end
            // Read data arrives one clk after the strobe; SCL is still low here,
            // so the MSB goes on the bus as soon as it is latched
            if (rd_wait && state_q == RD_DATA) begin
                shreg  <= i_mem_rdata;
                sda_oe <= ~i_mem_rdata[7];
            end
            case (state_q)
                DEV_ADDR, PTR_MSB, PTR_LSB, WR_DATA: begin
                    if (scl_rise) begin
                        shreg   <= {shreg[6:0], sda_f};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            done     <= 1'b1;
                            wen_pend <= (state_q == WR_DATA);
                        end
                    end else if (scl_fall && done) begin
                        sda_oe <= (state_q != DEV_ADDR) || addr_match;
                        if (state_q == PTR_MSB) ptr[P_ADDR_WIDTH-1 -: 8] <= shreg;
                        if (state_q == PTR_LSB) ptr[7:0] <= shreg;
                    end
                end
                DEV_ACK, MSB_ACK, LSB_ACK, WR_ACK: begin
                    if (scl_rise) done <= 1'b1;
                    else if (scl_fall && done) begin
                        sda_oe <= 1'b0;
                        if (state_q == WR_ACK) ptr <= ptr + PTR_ONE;
                        if (state_q == DEV_ACK && shreg[0]) begin
                            o_mem_ren  <= 1'b1;
                            o_mem_addr <= ptr;
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) done <= 1'b1;
                    end else if (scl_fall) begin
                        if (done) sda_oe <= 1'b0;
                        else begin
                            sda_oe <= ~shreg[6];
                            shreg  <= {shreg[6:0], 1'b0};
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        done    <= 1'b1;
                        ack_bit <= sda_f;
                    end else if (scl_fall && done && !ack_bit) begin
                        ptr        <= ptr + PTR_ONE;
                        o_mem_ren  <= 1'b1;
                        o_mem_addr <= ptr + PTR_ONE;
                    end
                end
                default: ;
            endcase
            if (start_det || state_d != state_q) begin
                bit_cnt <= '0;
                done    <= 1'b0;
            end
            if (start_det || stop_det) sda_oe <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bit-banged I2C master, memory model and a
// scoreboard of expected write/read strobes and returned bytes.
module tb_i2c_slave_responder;

    localparam int Q = 6;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n, scl, m_oe;
    wire         sda;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_wen, mem_ren, busy;
    logic [7:0]  mem [0:255];

    wr_t         exp_wr[$];
    logic [15:0] exp_rd[$];
    logic [7:0]  exp_byte[$];
    int          errs = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    assign sda = m_oe ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave_responder dut (
        .clk(clk), .rst_n(rst_n), .i_i2c_scl(scl), .io_i2c_sda(sda),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wen(mem_wen),
        .o_mem_ren(mem_ren), .i_mem_rdata(mem_rdata), .o_busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Synchronous read memory: data one clk after the strobe
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= mem[mem_addr[7:0]];
    end

    // Scoreboard: every strobe must match the head of its queue
    always @(negedge clk) begin : mon
        wr_t         e;
        logic [15:0] ra;
        if (rst_n && mem_wen) begin
            chk("wen_expected", 32'(exp_wr.size() != 0), 1);
            if (exp_wr.size() != 0) begin
                e = exp_wr.pop_front();
                chk("wen_addr", mem_addr, e.a);
                chk("wen_data", mem_wdata, e.d);
            end
        end
        if (rst_n && mem_ren) begin
            chk("ren_expected", 32'(exp_rd.size() != 0), 1);
            if (exp_rd.size() != 0) begin
                ra = exp_rd.pop_front();
                chk("ren_addr", mem_addr, ra);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_cyc(input logic drive_low, output logic smp);
        ticks(Q); m_oe = drive_low;
        ticks(Q); scl = 1'b1;
        ticks(Q); smp = sda;
        ticks(Q); scl = 1'b0;
    endtask

    // Works from idle and as a repeated START from SCL low
    task automatic m_start;
        ticks(Q); m_oe = 1'b0;
        ticks(Q); scl = 1'b1;
        ticks(Q); m_oe = 1'b1;
        ticks(Q); scl = 1'b0;
    endtask

    task automatic m_stop;
        ticks(Q); m_oe = 1'b1;
        ticks(Q); scl = 1'b1;
        ticks(Q); m_oe = 1'b0;
        ticks(2*Q);
    endtask

    task automatic m_wbyte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cyc(~b[i], s);
        bit_cyc(1'b0, ack);
    endtask

    task automatic m_rbyte(input logic nack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cyc(1'b0, s);
            b[i] = s;
        end
        bit_cyc(~nack, s);
    endtask

    initial begin
        logic       a, s, seen;
        logic [7:0] rb;
        rst_n = 1'b0; scl = 1'b1; m_oe = 1'b0;
        mem[8'h10] = 8'h77;
        mem[8'h11] = 8'h88;
        ticks(5);
        chk("rst_busy", busy, 0);
        chk("rst_wen", mem_wen, 0);
        chk("rst_ren", mem_ren, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_sda", sda, 1);
        rst_n = 1'b1;
        ticks(5);

        // Two-byte write at 0x1234
        m_start;
        m_wbyte(8'hA0, a); chk("wr_ack_dev", a, 0);
        m_wbyte(8'h12, a); chk("wr_ack_msb", a, 0);
        m_wbyte(8'h34, a); chk("wr_ack_lsb", a, 0);
        exp_wr.push_back('{16'h1234, 8'h5A});
        m_wbyte(8'h5A, a); chk("wr_ack_d0", a, 0);
        exp_wr.push_back('{16'h1235, 8'hC3});
        m_wbyte(8'hC3, a); chk("wr_ack_d1", a, 0);
        chk("wr_busy", busy, 1);
        m_stop;
        chk("wr_busy_stop", busy, 0);

        // Random read: set pointer 0x0010, Sr, read two bytes
        m_start;
        m_wbyte(8'hA0, a); chk("rr_ack_dev", a, 0);
        m_wbyte(8'h00, a); chk("rr_ack_msb", a, 0);
        m_wbyte(8'h10, a); chk("rr_ack_lsb", a, 0);
        m_start;
        exp_rd.push_back(16'h0010);
        m_wbyte(8'hA1, a); chk("rr_ack_rd", a, 0);
        exp_byte.push_back(8'h77);
        exp_rd.push_back(16'h0011);
        m_rbyte(1'b0, rb); chk("rr_byte0", rb, exp_byte.pop_front());
        exp_byte.push_back(8'h88);
        m_rbyte(1'b1, rb); chk("rr_byte1", rb, exp_byte.pop_front());
        m_stop;

        // Address mismatch then normal response
        m_start;
        m_wbyte(8'hA2, a); chk("mm_nack", a, 1);
        chk("mm_busy", busy, 1);
        m_start;
        m_wbyte(8'hA0, a); chk("mm_ack_after", a, 0);
        m_stop;

        // Pointer wrap at 0xFFFF
        m_start;
        m_wbyte(8'hA0, a); chk("wp_ack_dev", a, 0);
        m_wbyte(8'hFF, a); chk("wp_ack_msb", a, 0);
        m_wbyte(8'hFF, a); chk("wp_ack_lsb", a, 0);
        exp_wr.push_back('{16'hFFFF, 8'h11});
        m_wbyte(8'h11, a); chk("wp_ack_d0", a, 0);
        exp_wr.push_back('{16'h0000, 8'h22});
        m_wbyte(8'h22, a); chk("wp_ack_d1", a, 0);
        m_stop;

        // STOP after 4 data bits: no write
        m_start;
        m_wbyte(8'hA0, a);
        m_wbyte(8'h00, a);
        m_wbyte(8'h20, a); chk("ab_ack_lsb", a, 0);
        for (int i = 0; i < 4; i++) bit_cyc(i[0], s);
        m_stop;
        chk("ab_busy", busy, 0);
        chk("ab_wr_q", exp_wr.size(), 0);

        // Reset while the DUT drives a 0 data bit
        m_start;
        m_wbyte(8'hA0, a);
        m_wbyte(8'h00, a);
        m_wbyte(8'h10, a);
        m_start;
        exp_rd.push_back(16'h0010);
        m_wbyte(8'hA1, a); chk("rs_ack_rd", a, 0);
        ticks(10);
        chk("rs_sda_driven", sda, 0);
        rst_n = 1'b0;
        #1;
        chk("rs_sda", sda, 1);
        chk("rs_busy", busy, 0);
        chk("rs_ren", mem_ren, 0);
        chk("rs_wen", mem_wen, 0);
        chk("rs_addr", mem_addr, 0);
        chk("rs_wdata", mem_wdata, 0);
        ticks(3);
        scl = 1'b1;
        rst_n = 1'b1;
        ticks(10);

        // 1-clk SDA low pulse while SCL is high
        seen = 1'b0;
        m_oe = 1'b1;
        ticks(1);
        m_oe = 1'b0;
        for (int i = 0; i < 12; i++) begin
            ticks(1);
            if (busy) seen = 1'b1;
        end
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        chk("glitch_busy", seen, 0);
`else
        chk("glitch_busy", seen, 1);
`endif
        chk("glitch_idle", busy, 0);

        chk("end_wr_q", exp_wr.size(), 0);
        chk("end_rd_q", exp_rd.size(), 0);
        chk("end_byte_q", exp_byte.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
